// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: opcode patterns, FSM states, ALU ops and the
// instruction classifier used by the multi-cycle datapath.
package legv8_pkg;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [5:0]  OP_B    = 6'b000101;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   typedef enum logic [2:0] {ADD, SUB, AND, ORR, PASS} alu_op_t;

   typedef enum logic [3:0] {
      I_ADD, I_SUB, I_AND, I_ORR, I_LDUR, I_STUR, I_CBZ, I_B, I_ILL
   } ins_class_t;

   // Classify an instruction word; the narrower CBZ/B fields are tested first.
   function automatic ins_class_t decode_ins(input logic [31:0] ir);
      if (ir[31:24] == OP_CBZ) return I_CBZ;
      if (ir[31:26] == OP_B)   return I_B;
      case (ir[31:21])
         OP_ADD:  return I_ADD;
         OP_SUB:  return I_SUB;
         OP_AND:  return I_AND;
         OP_ORR:  return I_ORR;
         OP_LDUR: return I_LDUR;
         OP_STUR: return I_STUR;
         default: return I_ILL;
      endcase
   endfunction

endpackage

// File: rtl/param_alu.sv
// Width-parametrised ALU: add/sub/and/orr, or pass-through of operand b.
module param_alu
   import legv8_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   always_comb begin
      result = b;
      case (alu_op_t'(op))
         ADD:     result = a + b;
         SUB:     result = a - b;
         AND:     result = a & b;
         ORR:     result = a | b;
         default: result = b;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle LEGv8 datapath (ADD/SUB/AND/ORR/LDUR/STUR/CBZ/B) with handshaked
// instruction/data memories, external register file, halt-on-illegal and instret.
module multicycle_datapath
   import legv8_pkg::*;
#(
   parameter int unsigned     WIDTH    = 64,
   parameter longint unsigned RESET_PC = 0,
   parameter int unsigned     CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] ins_Addr,
   output logic             ins_req,
   input  logic             ins_ready,
   input  logic [31:0]      ins,
   output logic [WIDTH-1:0] memAddr,
   output logic [WIDTH-1:0] memWriteData,
   output logic             MemRead,
   output logic             MemWrite,
   input  logic             mem_ready,
   input  logic [WIDTH-1:0] memReadData,
   output logic [4:0]       rReadSelect1,
   output logic [4:0]       rReadSelect2,
   output logic [4:0]       rWriteSelect,
   output logic [WIDTH-1:0] rWriteData,
   output logic             rWriteEnable,
   input  logic [WIDTH-1:0] rReadData1,
   input  logic [WIDTH-1:0] rReadData2,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);

   state_t           state, state_next;
   logic [WIDTH-1:0] pc, a_q, b_q, alu_out, mdr;
   logic [31:0]      ir;
   ins_class_t       cls;

   logic [WIDTH-1:0] imm_d, imm_cbz, imm_b, br_off, pc_inc, pc_next;
   logic [WIDTH-1:0] alu_b, alu_result;
   logic             alu_zero;
   alu_op_t          alu_op;
   logic             ld_ir, ld_ab, ld_alu, ld_mdr, pc_ld, retire, set_halt;

   assign cls     = decode_ins(ir);
   assign imm_d   = WIDTH'($signed(ir[20:12]));
   assign imm_cbz = WIDTH'($signed(ir[23:5]));
   assign imm_b   = WIDTH'($signed(ir[25:0]));
   assign br_off  = (cls == I_B) ? imm_b : imm_cbz;
   assign pc_inc  = pc + WIDTH'(1);

   assign ins_Addr     = pc;
   assign memAddr      = alu_out;
   assign memWriteData = b_q;
   assign rReadSelect1 = ir[9:5];
   assign rReadSelect2 = (cls == I_STUR || cls == I_CBZ) ? ir[4:0] : ir[20:16];
   assign rWriteSelect = ir[4:0];
   assign rWriteData   = (cls == I_LDUR) ? mdr : alu_out;

   param_alu #(.WIDTH(WIDTH)) u_alu (
      .op     (alu_op),
      .a      (a_q),
      .b      (alu_b),
      .result (alu_result),
      .zero   (alu_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else     state <= state_next;
   end

   // Next state, handshake outputs and datapath load strobes.
   always_comb begin
      state_next   = state;
      ins_req      = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      rWriteEnable = 1'b0;
      ld_ir        = 1'b0;
      ld_ab        = 1'b0;
      ld_alu       = 1'b0;
      ld_mdr       = 1'b0;
      pc_ld        = 1'b0;
      pc_next      = pc_inc;
      retire       = 1'b0;
      set_halt     = 1'b0;
      alu_op       = ADD;
      alu_b        = b_q;
      case (state)
         FETCH: begin
            ins_req = 1'b1;
            if (ins_ready) begin
               ld_ir      = 1'b1;
               state_next = DECODE;
            end
         end
         DECODE: begin
            ld_ab = 1'b1;
            if (cls == I_ILL) begin
               set_halt   = 1'b1;
               state_next = HALT;
            end else begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            ld_alu = 1'b1;
            case (cls)
               I_ADD:  begin alu_op = ADD; state_next = WB; end
               I_SUB:  begin alu_op = SUB; state_next = WB; end
               I_AND:  begin alu_op = AND; state_next = WB; end
               I_ORR:  begin alu_op = ORR; state_next = WB; end
               I_LDUR, I_STUR: begin
                  alu_b      = imm_d;
                  state_next = MEM;
               end
               I_CBZ: begin
                  alu_op     = PASS;
                  pc_ld      = 1'b1;
                  pc_next    = alu_zero ? (pc + br_off) : pc_inc;
                  retire     = 1'b1;
                  state_next = FETCH;
               end
               I_B: begin
                  pc_ld      = 1'b1;
                  pc_next    = pc + br_off;
                  retire     = 1'b1;
                  state_next = FETCH;
               end
               default: state_next = HALT;
            endcase
         end
         MEM: begin
            if (cls == I_LDUR) MemRead  = 1'b1;
            else               MemWrite = 1'b1;
            if (mem_ready) begin
               if (cls == I_LDUR) begin
                  ld_mdr     = 1'b1;
                  state_next = WB;
               end else begin
                  pc_ld      = 1'b1;
                  retire     = 1'b1;
                  state_next = FETCH;
               end
            end
         end
         WB: begin
            rWriteEnable = 1'b1;
            pc_ld        = 1'b1;
            retire       = 1'b1;
            state_next   = FETCH;
         end
         HALT:    state_next = HALT;
         default: state_next = FETCH;
      endcase
      // Reset squashes any outstanding request or write in the current cycle.
      if (rst) begin
         ins_req      = 1'b0;
         MemRead      = 1'b0;
         MemWrite     = 1'b0;
         rWriteEnable = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= WIDTH'(RESET_PC);
         ir      <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_out <= '0;
         mdr     <= '0;
         instret <= '0;
         halted  <= 1'b0;
      end else begin
         if (ld_ir)    ir      <= ins;
         if (ld_ab) begin
            a_q <= rReadData1;
            b_q <= rReadData2;
         end
         if (ld_alu)   alu_out <= alu_result;
         if (ld_mdr)   mdr     <= memReadData;
         if (pc_ld)    pc      <= pc_next;
         if (retire)   instret <= instret + CNT_W'(1);
         if (set_halt) halted  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: behavioural register file and memories
// with programmable wait states, hand-computed expectations per instruction.
module tb_multicycle_datapath;

   localparam logic [63:0] RD_KEY = 64'h5A5A_0000_0000_1234;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic [63:0] ins_Addr, memAddr, memWriteData, memReadData, rWriteData;
   logic [63:0] rReadData1, rReadData2;
   logic        ins_req, ins_ready, MemRead, MemWrite, mem_ready, rWriteEnable, halted;
   logic [31:0] ins, instret;
   logic [4:0]  rReadSelect1, rReadSelect2, rWriteSelect;

   logic [31:0] imem [64];
   logic [63:0] regs [32];
   int          ins_wait = 0, mem_wait = 0, ins_cnt = 0, mem_cnt = 0;
   logic        preset_en = 1'b0;
   logic [4:0]  preset_idx = '0;
   logic [63:0] preset_val = '0;
   int          st_cnt = 0;
   logic [63:0] st_addr = '0, st_data = '0;

   multicycle_datapath dut (
      .clk(clk), .rst(rst),
      .ins_Addr(ins_Addr), .ins_req(ins_req), .ins_ready(ins_ready), .ins(ins),
      .memAddr(memAddr), .memWriteData(memWriteData),
      .MemRead(MemRead), .MemWrite(MemWrite),
      .mem_ready(mem_ready), .memReadData(memReadData),
      .rReadSelect1(rReadSelect1), .rReadSelect2(rReadSelect2),
      .rWriteSelect(rWriteSelect), .rWriteData(rWriteData),
      .rWriteEnable(rWriteEnable),
      .rReadData1(rReadData1), .rReadData2(rReadData2),
      .halted(halted), .instret(instret)
   );

   // 32-bit instance that endlessly executes "B #-1" from PC 0.
   logic [31:0] pc32, maddr32, mwd32, rwd32, instret32;
   logic        req32, mrd32, mwr32, rwe32, halted32;
   logic [4:0]  rs1_32, rs2_32, ws32;

   multicycle_datapath #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst),
      .ins_Addr(pc32), .ins_req(req32), .ins_ready(req32), .ins(32'h17FF_FFFF),
      .memAddr(maddr32), .memWriteData(mwd32),
      .MemRead(mrd32), .MemWrite(mwr32),
      .mem_ready(1'b0), .memReadData(32'h0),
      .rReadSelect1(rs1_32), .rReadSelect2(rs2_32),
      .rWriteSelect(ws32), .rWriteData(rwd32),
      .rWriteEnable(rwe32),
      .rReadData1(32'h0), .rReadData2(32'h0),
      .halted(halted32), .instret(instret32)
   );

   assign ins         = imem[ins_Addr[5:0]];
   assign ins_ready   = ins_req && (ins_cnt >= ins_wait);
   assign mem_ready   = (MemRead || MemWrite) && (mem_cnt >= mem_wait);
   assign memReadData = memAddr ^ RD_KEY;
   assign rReadData1  = regs[rReadSelect1];
   assign rReadData2  = regs[rReadSelect2];

   always @(posedge clk) begin
      if (preset_en)         regs[preset_idx] <= preset_val;
      else if (rWriteEnable) regs[rWriteSelect] <= rWriteData;
      ins_cnt <= (rst || !ins_req || ins_ready) ? 0 : ins_cnt + 1;
      mem_cnt <= (rst || !(MemRead || MemWrite) || mem_ready) ? 0 : mem_cnt + 1;
      if (MemWrite && mem_ready) begin
         st_cnt  <= st_cnt + 1;
         st_addr <= memAddr;
         st_data <= memWriteData;
      end
   end

   int n_chk = 0, n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                         input logic [4:0] rn, input logic [4:0] rd);
      return {op, rm, 6'd0, rn, rd};
   endfunction

   function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm,
                                         input logic [4:0] rn, input logic [4:0] rt);
      return {op, imm, 2'b00, rn, rt};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_reg(input logic [4:0] idx, input logic [63:0] val);
      preset_idx = idx;
      preset_val = val;
      preset_en  = 1'b1;
      @(posedge clk);
      #1 preset_en = 1'b0;
   endtask

   // Hold reset, check reset state, then release; returns mid-cycle 1.
   task automatic start(input logic [63:0] x1, input logic [63:0] x2);
      rst = 1'b1;
      set_reg(5'd1, x1);
      set_reg(5'd2, x2);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ins_req", 64'(ins_req), 64'd0);
      check("rst_mem_req", 64'({MemRead, MemWrite, rWriteEnable}), 64'd0);
      check("rst_pc", ins_Addr, 64'd0);
      check("rst_instret_halted", {31'd0, halted, instret}, 64'd0);
      rst = 1'b0;
      #1;
      check("c1_ins_req", 64'(ins_req), 64'd1);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = 32'h0;
   endtask

   int cnt;

   initial begin
      clear_imem();

      // ADD X3,X1,X2 with 5+7, zero wait.
      imem[0] = enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3);
      start(64'd5, 64'd7);
      step(); step();
      check("add_c3_we", 64'(rWriteEnable), 64'd0);
      step();
      check("add_c4_we", 64'(rWriteEnable), 64'd1);
      check("add_c4_sel", 64'(rWriteSelect), 64'd3);
      check("add_c4_data", rWriteData, 64'd12);
      check("b32_pc", 64'(pc32), 64'hFFFF_FFFF);
      check("b32_instret", 64'(instret32), 64'd1);
      step();
      check("add_c5_we", 64'(rWriteEnable), 64'd0);
      check("add_pc", ins_Addr, 64'd1);
      check("add_instret", 64'(instret), 64'd1);
      check("add_x3", regs[3], 64'd12);

      // ADD/SUB/AND/ORR program ending on an illegal word.
      clear_imem();
      imem[0] = enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3);
      imem[1] = enc_r(11'b11001011000, 5'd1, 5'd2, 5'd4);
      imem[2] = enc_r(11'b10001010000, 5'd2, 5'd1, 5'd5);
      imem[3] = enc_r(11'b10101010000, 5'd2, 5'd1, 5'd6);
      start(64'hC, 64'hA);
      for (int i = 0; i < 40 && !halted; i++) step();
      check("prog_halted", 64'(halted), 64'd1);
      check("prog_add", regs[3], 64'h16);
      check("prog_sub", regs[4], 64'hFFFF_FFFF_FFFF_FFFE);
      check("prog_and", regs[5], 64'h8);
      check("prog_orr", regs[6], 64'hE);
      check("prog_instret", 64'(instret), 64'd4);
      check("prog_pc", ins_Addr, 64'd4);

      // LDUR X4,[X1,#-8] with 3 data wait cycles.
      clear_imem();
      imem[0] = enc_d(11'b11111000010, 9'h1F8, 5'd1, 5'd4);
      mem_wait = 3;
      start(64'h100, 64'd0);
      step(); step(); step();
      cnt = 0;
      for (int c = 4; c <= 8; c++) begin
         if (MemRead) cnt++;
         if (c == 4) check("ldur_addr", memAddr, 64'hF8);
         if (c == 8) begin
            check("ldur_c8_we", 64'(rWriteEnable), 64'd1);
            check("ldur_c8_sel", 64'(rWriteSelect), 64'd4);
            check("ldur_c8_data", rWriteData, 64'hF8 ^ RD_KEY);
         end
         if (c < 8) step();
      end
      check("ldur_rd_cycles", 64'(cnt), 64'd4);
      step();
      check("ldur_x4", regs[4], 64'hF8 ^ RD_KEY);
      check("ldur_pc", ins_Addr, 64'd1);

      // STUR X2,[X1,#16] with 2 fetch wait cycles, zero data wait.
      clear_imem();
      imem[0] = enc_d(11'b11111000000, 9'd16, 5'd1, 5'd2);
      ins_wait = 2;
      mem_wait = 0;
      start(64'h100, 64'h55);
      step();
      check("stur_c2_req_held", {63'd0, ins_req}, 64'd1);
      step(); step(); step(); step();
      check("stur_c6_wr", 64'({MemRead, MemWrite}), 64'd1);
      check("stur_c6_addr", memAddr, 64'h110);
      check("stur_c6_data", memWriteData, 64'h55);
      step();
      check("stur_c7_wr", 64'(MemWrite), 64'd0);
      check("stur_pc", ins_Addr, 64'd1);
      check("stur_instret", 64'(instret), 64'd1);
      check("stur_store", {st_addr[31:0], st_data[31:0]}, {32'h110, 32'h55});
      ins_wait = 0;

      // B #10 then CBZ X2,#-2 at PC 10, taken and not taken.
      for (int t = 0; t < 2; t++) begin
         clear_imem();
         imem[0]  = {6'b000101, 26'd10};
         imem[10] = {8'b10110100, 19'h7FFFE, 5'd2};
         start(64'd0, 64'(t));
         step(); step(); step();
         check("cbz_c4_pc", ins_Addr, 64'd10);
         step(); step(); step();
         check(t == 0 ? "cbz_taken_pc" : "cbz_fall_pc", ins_Addr, t == 0 ? 64'd8 : 64'd11);
         check("cbz_instret", 64'(instret), 64'd2);
      end

      // Illegal all-zero opcode halts after DECODE and stays frozen.
      clear_imem();
      start(64'd0, 64'd0);
      step();
      check("ill_c2_halted", 64'(halted), 64'd0);
      step();
      check("ill_c3_halted", 64'(halted), 64'd1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (ins_req || MemRead || MemWrite || rWriteEnable) cnt++;
         step();
      end
      check("ill_no_req", 64'(cnt), 64'd0);
      check("ill_instret", 64'(instret), 64'd0);
      check("ill_pc", ins_Addr, 64'd0);

      // Reset while a STUR is stalled in MEM.
      clear_imem();
      imem[0] = enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3);
      imem[1] = enc_d(11'b11111000000, 9'd16, 5'd1, 5'd2);
      mem_wait = 1000;
      start(64'h100, 64'h55);
      repeat (8) step();
      check("stall_c9_wr", 64'(MemWrite), 64'd1);
      check("stall_c9_instret", 64'(instret), 64'd1);
      rst = 1'b1;
      step();
      check("abort_wr", 64'(MemWrite), 64'd0);
      check("abort_pc", ins_Addr, 64'd0);
      check("abort_instret", 64'(instret), 64'd0);
      check("abort_halted", 64'(halted), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
